// File: rtl/jtframe_uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package jtframe_uart_arb_pkg;

    // Arbiter FSM states. TAG is only entered when JTFRAME_UART_ARB_TAG_EN is defined.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } state_t;

    // Upper nibble of the packet tag byte; the owner index fills the low bits.
    localparam logic [7:0] TAG_BASE = 8'hF0;

    // Width of the per-grant byte counter, enough for MAXLEN up to 31.
    localparam int CNT_W = 5;

    function automatic logic [7:0] tag_byte(input logic [2:0] idx);
        return TAG_BASE | {5'd0, idx};
    endfunction

endpackage

// File: rtl/jtframe_uart_rr.sv
// Combinational N-input round-robin picker: first requester at or after ptr_i, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to act on the pick.
//
// Ports:
//   req_i     in  N      request vector
//   ptr_i     in  IDX_W  index with highest priority this round
//   any_o     out 1      at least one request present
//   onehot_o  out N      one-hot winner (0 when any_o=0)
//   idx_o     out IDX_W  binary winner index (0 when any_o=0)
module jtframe_uart_rr #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o
);

    // rot[k] is the request of index (ptr + k) mod N, so the lowest set bit
    // of rot is the winner, measured as a distance from the pointer.
    logic [N-1:0]   rot;
    logic [IDX_W:0] sum;

    always_comb begin
        rot      = N'({req_i, req_i} >> ptr_i);
        any_o    = 1'b0;
        idx_o    = '0;
        sum      = '0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && rot[k]) begin
                any_o = 1'b1;
                sum   = {1'b0, ptr_i} + (IDX_W+1)'(k);
                if (sum >= (IDX_W+1)'(N)) begin
                    sum = sum - (IDX_W+1)'(N);
                end
                idx_o = sum[IDX_W-1:0];
            end
        end
        onehot_o = any_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/jtframe_uart_arb.sv
// Round-robin arbiter sharing one UART transmitter among N requesters, granting whole packets.
// Latency: grant one cen after req seen; tx_wr/ack one cen later; next byte one cen after tx_done.
// Backpressure: req held until ack; UART tx_done paces bytes; tx_busy in IDLE blocks new grants.
//
// Optional feature macro: JTFRAME_UART_ARB_TAG_EN -- prefix each packet with 8'hF0|idx.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   cen               clock enable shared with the UART; all state moves only when high
//   req/last/data     per-requester byte valid, end-of-packet flag and byte (data[8*i+7:8*i])
//   ack               one-cen pulse per byte accepted from requester i
//   grant             one-hot current owner, 0 when idle
//   uart_tx_data/wr   byte and one-cen write strobe to the UART
//   uart_tx_busy/done UART status inputs
module jtframe_uart_arb
    import jtframe_uart_arb_pkg::*;
#(
    parameter int N      = 4,
    parameter int MAXLEN = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   last,
    input  logic [8*N-1:0] data,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   grant,
    output logic [7:0]     uart_tx_data,
    output logic           uart_tx_wr,
    input  logic           uart_tx_busy,
    input  logic           uart_tx_done
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;
    logic             tag_q;
    logic [N-1:0]     grant_q;
    logic [N-1:0]     ack_q;
    logic             wr_q;
    logic [7:0]       tx_data_q;

    logic             pick_any;
    logic [N-1:0]     pick_onehot;
    logic [IDX_W-1:0] pick_idx;

    logic             req_own;
    logic             last_own;
    logic [7:0]       byte_own;
    logic [IDX_W-1:0] ptr_d;
    logic [CNT_W-1:0] cnt_d;
    logic             release_d;

    jtframe_uart_rr #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .any_o    (pick_any),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    // Lane select for the current owner.
    always_comb begin
        req_own  = 1'b0;
        last_own = 1'b0;
        byte_own = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                req_own  = req[i];
                last_own = last[i];
                byte_own = data[8*i +: 8];
            end
        end
    end

    always_comb begin
        ptr_d     = (idx_q == IDX_W'(N-1)) ? '0 : idx_q + 1'b1;
        cnt_d     = cnt_q + 1'b1;
        // A tag byte never ends the grant; only data bytes are judged.
        release_d = !tag_q && (last_q || (cnt_q == CNT_W'(MAXLEN)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            tag_q     <= 1'b0;
            grant_q   <= '0;
            ack_q     <= '0;
            wr_q      <= 1'b0;
            tx_data_q <= '0;
        end else if (cen) begin
            // Strobes last exactly one cen cycle.
            wr_q  <= 1'b0;
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_any && !uart_tx_busy) begin
                        grant_q <= pick_onehot;
                        idx_q   <= pick_idx;
                        cnt_q   <= '0;
`ifdef JTFRAME_UART_ARB_TAG_EN
                        state_q <= TAG;
`else
                        state_q <= SEND;
`endif
                    end
                end
                TAG: begin
                    tx_data_q <= tag_byte(3'(idx_q));
                    wr_q      <= 1'b1;
                    tag_q     <= 1'b1;
                    state_q   <= WAIT;
                end
                SEND: begin
                    // A paused owner simply keeps the grant.
                    if (req_own) begin
                        tx_data_q <= byte_own;
                        wr_q      <= 1'b1;
                        ack_q     <= grant_q;
                        last_q    <= last_own;
                        tag_q     <= 1'b0;
                        cnt_q     <= cnt_d;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (uart_tx_done) begin
                        if (release_d) begin
                            grant_q <= '0;
                            ptr_q   <= ptr_d;
                            state_q <= IDLE;
                        end else begin
                            state_q <= SEND;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack          = ack_q;
    assign grant        = grant_q;
    assign uart_tx_wr   = wr_q;
    assign uart_tx_data = tx_data_q;

endmodule
